alu_arbiter: RTL and testbench

Shares the single datapath ALU between two micro-op requesters, such as the microsequencer and the operand-stack unit. It arbitrates with round-robin priority and translates a 4-bit abstract opcode into the ALU's 6-bit control word. It drives the ALU operands, then captures the ALU result and the registered N/Z flags. Flags are captured one cycle after the result because the ALU updates N/Z on the clock edge after `out` settles. Each operation returns a one-cycle `done` pulse to the served requester.

---
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one datapath ALU between two micro-op requesters.
// Maps a 4-bit abstract opcode onto the ALU control word and returns result, N/Z flags and a done pulse.
module alu_arbiter #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [3:0]            op0,
  input  logic [3:0]            op1,
  input  logic [WORD_WIDTH-1:0] a0,
  input  logic [WORD_WIDTH-1:0] b0,
  input  logic [WORD_WIDTH-1:0] a1,
  input  logic [WORD_WIDTH-1:0] b1,
  output logic                  done0,
  output logic                  done1,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  res_n,
  output logic                  res_z,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] alu_a,
  output logic [WORD_WIDTH-1:0] alu_b,
  output logic [5:0]            alu_control,
  input  logic [WORD_WIDTH-1:0] alu_out,
  input  logic                  alu_n,
  input  logic                  alu_z
);

  typedef enum logic [1:0] {IDLE, DRIVE, FLAGS, RESP} state_t;

  state_t                state;
  logic                  last;
  logic                  grant;
  logic                  win;
  logic [3:0]            win_op;
  logic [WORD_WIDTH-1:0] win_a;
  logic [WORD_WIDTH-1:0] win_b;
  logic [5:0]            win_ctl;

  // On a tie the requester not served last wins; a lone request always wins.
  always_comb begin
    win     = req0 ? (req1 ? ~last : 1'b0) : 1'b1;
    win_op  = win ? op1 : op0;
    win_a   = win ? a1 : a0;
    win_b   = win ? b1 : b0;
    win_ctl = 6'b010000;
    case (win_op)
      4'd0:  win_ctl = 6'b011000;
      4'd1:  win_ctl = 6'b010100;
      4'd2:  win_ctl = 6'b011010;
      4'd3:  win_ctl = 6'b101100;
      4'd4:  win_ctl = 6'b111100;
      4'd5:  win_ctl = 6'b111101;
      4'd6:  win_ctl = 6'b111001;
      4'd7:  win_ctl = 6'b110101;
      4'd8:  win_ctl = 6'b111111;
      4'd9:  win_ctl = 6'b110110;
      4'd10: win_ctl = 6'b111011;
      4'd11: win_ctl = 6'b001100;
      4'd12: win_ctl = 6'b011100;
      4'd13: win_ctl = 6'b010000;
      4'd14: win_ctl = 6'b010001;
      4'd15: win_ctl = 6'b010010;
      default: win_ctl = 6'b010000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      grant       <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      busy        <= 1'b0;
      result      <= '0;
      res_n       <= 1'b0;
      res_z       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= 6'b010000;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            alu_a       <= win_a;
            alu_b       <= win_b;
            alu_control <= win_ctl;
            grant       <= win;
            last        <= win;
            busy        <= 1'b1;
            state       <= DRIVE;
          end
        end
        DRIVE: begin
          result <= alu_out;
          state  <= FLAGS;
        end
        // The ALU registers N/Z on the same edge that captured result, so they are valid here.
        FLAGS: begin
          res_n <= alu_n;
          res_z <= alu_z;
          done0 <= ~grant;
          done1 <= grant;
          state <= RESP;
        end
        RESP: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: behavioural ALU stand-in, predicted grant schedule, decoupled monitor.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [3:0]   op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         done0, done1, res_n, res_z, busy;
  logic [W-1:0] result, alu_a, alu_b, alu_out;
  logic [5:0]   alu_control;
  logic         alu_n = 1'b0, alu_z = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tb_last = 1'b1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } opnd_t;

  typedef struct {
    bit           who;
    int           done_cyc;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  opnd_t l0[$];
  opnd_t l1[$];
  exp_t  order[$];

  alu_arbiter #(.WORD_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1),
    .result(result), .res_n(res_n), .res_z(res_z), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the datapath ALU: decodes the control word, registers N/Z.
  always_comb begin
    alu_out = '0;
    case (alu_control)
      6'b011000: alu_out = alu_a;
      6'b010100: alu_out = alu_b;
      6'b011010: alu_out = ~alu_a;
      6'b101100: alu_out = ~alu_b;
      6'b111100: alu_out = alu_a + alu_b;
      6'b111101: alu_out = alu_a + alu_b + 1;
      6'b111001: alu_out = alu_a + 1;
      6'b110101: alu_out = alu_b + 1;
      6'b111111: alu_out = alu_b - alu_a;
      6'b110110: alu_out = alu_b - 1;
      6'b111011: alu_out = 0 - alu_a;
      6'b001100: alu_out = alu_a & alu_b;
      6'b011100: alu_out = alu_a | alu_b;
      6'b010000: alu_out = '0;
      6'b010001: alu_out = 1;
      6'b010010: alu_out = '1;
      default:   alu_out = '0;
    endcase
  end

  always @(posedge clk) begin
    alu_n <= alu_out[W-1];
    alu_z <= (alu_out == '0);
  end

  function automatic logic [5:0] ctl_of(input logic [3:0] op);
    logic [5:0] t [16] = '{6'b011000, 6'b010100, 6'b011010, 6'b101100,
                           6'b111100, 6'b111101, 6'b111001, 6'b110101,
                           6'b111111, 6'b110110, 6'b111011, 6'b001100,
                           6'b011100, 6'b010000, 6'b010001, 6'b010010};
    return t[op];
  endfunction

  function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      4'd0:  r = a;
      4'd1:  r = b;
      4'd2:  r = ~a;
      4'd3:  r = ~b;
      4'd4:  r = a + b;
      4'd5:  r = a + b + 1;
      4'd6:  r = a + 1;
      4'd7:  r = b + 1;
      4'd8:  r = b - a;
      4'd9:  r = b - 1;
      4'd10: r = 0 - a;
      4'd11: r = a & b;
      4'd12: r = a | b;
      4'd13: r = 0;
      4'd14: r = 1;
      default: r = '1;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: operands/control in DRIVE, then result/flags/who/latency at each done pulse.
  always @(negedge clk) begin
    if (order.size() > 0 && cyc == order[0].done_cyc - 2) begin
      chk("alu_control", 64'(alu_control), 64'(ctl_of(order[0].op)));
      chk("alu_a", 64'(alu_a), 64'(order[0].a));
      chk("alu_b", 64'(alu_b), 64'(order[0].b));
    end
    if (done0 || done1) begin
      if (order.size() == 0) begin
        chk("unexpected_done", {62'd0, done1, done0}, 64'd0);
      end else begin
        exp_t e;
        logic [W-1:0] r;
        e = order.pop_front();
        r = ref_res(e.op, e.a, e.b);
        chk("done_who", {62'd0, done1, done0}, e.who ? 64'd2 : 64'd1);
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("result", 64'(result), 64'(r));
        chk("res_n", 64'(res_n), 64'(r[W-1]));
        chk("res_z", 64'(res_z), 64'(r == '0));
      end
    end
  end

  task automatic present0(input int i);
    op0 = l0[i].op; a0 = l0[i].a; b0 = l0[i].b; req0 = 1'b1;
  endtask

  task automatic present1(input int i);
    op1 = l1[i].op; a1 = l1[i].a; b1 = l1[i].b; req1 = 1'b1;
  endtask

  // Each requester issues its list back to back; the schedule is predicted from round-robin fairness.
  task automatic run_ops(input bit disturb);
    int n0 = l0.size();
    int n1 = l1.size();
    int r0 = n0, r1 = n1, i0 = 0, i1 = 0, k = 0, base, limit;
    bit w;
    exp_t e;
    @(negedge clk);
    base = cyc;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) w = ~tb_last;
      else w = (r1 > 0);
      e.who = w;
      e.done_cyc = base + 3 + 4 * k;
      if (w) begin e.op = l1[n1 - r1].op; e.a = l1[n1 - r1].a; e.b = l1[n1 - r1].b; r1--; end
      else   begin e.op = l0[n0 - r0].op; e.a = l0[n0 - r0].a; e.b = l0[n0 - r0].b; r0--; end
      order.push_back(e);
      tb_last = w;
      k++;
    end
    if (n0 > 0) present0(0);
    if (n1 > 0) present1(0);
    limit = base + 4 * (n0 + n1) + 12;
    while (order.size() != 0) begin
      @(negedge clk);
      if (disturb && cyc == base + 1) begin a0 = ~a0; req0 = 1'b0; end
      if (done0) begin i0++; if (i0 < n0) present0(i0); else req0 = 1'b0; end
      if (done1) begin i1++; if (i1 < n1) present1(i1); else req1 = 1'b0; end
      if (cyc > limit) begin
        chk("done_timeout", 64'(order.size()), 64'd0);
        order.delete();
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    l0.delete();
    l1.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, {62'd0, done1, done0}, 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_flags"}, {62'd0, res_n, res_z}, 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({tag, "_alu_control"}, 64'(alu_control), 64'(6'b010000));
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 3))
      0: return W'($urandom_range(0, 3));
      1: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    tb_last = 1'b1;

    // Single ops from each side, including negative and zero results.
    l0.push_back('{4'd4, 32'd5, 32'd7});
    run_ops(1'b0);
    l1.push_back('{4'd8, 32'd9, 32'd4});
    run_ops(1'b0);
    l1.push_back('{4'd13, 32'd9, 32'd4});
    run_ops(1'b0);

    // Both held for two ops each: grants alternate 0,1,0,1.
    for (int i = 0; i < 2; i++) begin
      l0.push_back('{4'(4 + i), W'($urandom), W'($urandom)});
      l1.push_back('{4'(11 + i), W'($urandom), W'($urandom)});
    end
    run_ops(1'b0);

    // Operand change and request drop during DRIVE must not affect the operation.
    l0.push_back('{4'd5, 32'd100, 32'd23});
    run_ops(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_after_drop", 64'(busy), 64'd0);
    end

    // Reset during FLAGS aborts without a done pulse.
    @(negedge clk);
    op0 = 4'd4; a0 = 32'd1; b0 = 32'd2; req0 = 1'b1;
    @(negedge clk);
    chk("busy_drive", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    tb_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", {62'd0, done1, busy}, 64'd0);
    end

    // Opcode sweep at the sign boundary.
    for (int op = 0; op < 16; op++) begin
      l0.push_back('{4'(op), 32'h8000_0000, 32'd1});
      run_ops(1'b0);
    end

    // Random contention rounds.
    repeat (30) begin
      int n0 = $urandom_range(0, 3);
      int n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) l0.push_back('{4'($urandom_range(0, 15)), rnd_word(), rnd_word()});
      for (int i = 0; i < n1; i++) l1.push_back('{4'($urandom_range(0, 15)), rnd_word(), rnd_word()});
      run_ops(1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
